store_checker: RTL and testbench
================================

// Module: store_checker
// PURPOSE
//  Synthesizable self-check monitor for the pipelined RV32I core. Watches the core's data-memory
//  write port, compares each store against a preloaded table of NUM_EXP expected (addr,data)
//  pairs and raises PASS/FAIL/TIMEOUT verdicts. Sits beside top in benches and FPGA
//  bring-up builds, replacing single-value end-of-program checks.
// PARAMETERS
//  ADDR_W      32    width of store address and expected-address entries
//  DATA_W      32    width of store data and expected-data entries
//  NUM_EXP     4     expected-store table depth (>=1); IDX_W = max(1,$clog2(NUM_EXP))
//  IGNORE_ADDR 96    stores to this address are skipped, never compared
//  IGNORE_EN   1     1 = IGNORE_ADDR filter active; 0 = every store is compared
//  ORDERED     1     1 = stores must match table in index order; 0 = any order, each entry once
//  TIMEOUT     4096  max cycles in RUN before TIMEOUT verdict (>=1); CNT_W = $clog2(TIMEOUT+1)
// PORTS
//  clk          in   1        clock; all logic on rising edge
//  rst          in   1        synchronous, active-low reset (rst==0 at posedge resets)
//  exp_wr_en    in   1        write expected entry (accepted in IDLE only)
//  exp_idx      in   IDX_W    table index for exp_wr_en
//  exp_addr     in   ADDR_W   expected store address
//  exp_data     in   DATA_W   expected store data
//  start        in   1        IDLE->RUN pulse
//  mem_write    in   1        core store strobe (one store per cycle when high)
//  data_addr_m  in   ADDR_W   core store address
//  write_data_m in   DATA_W   core store data
//  done         out  1        verdict reached (PASS/FAIL/TMO); sticky
//  pass         out  1        all NUM_EXP entries matched; sticky
//  fail         out  1        mismatch or timeout; sticky
//  fail_code    out  2        0 none, 1 addr/data mismatch, 2 timeout
//  match_cnt    out  IDX_W+1  entries matched so far
//  fail_addr    out  ADDR_W   address of offending store (0 unless fail_code==1)
//  fail_data    out  DATA_W   data of offending store (0 unless fail_code==1)
// BEHAVIOUR
//  - Reset: state=IDLE; done,pass,fail=0; fail_code=0; match_cnt=0; fail_addr,fail_data=0;
//    cycle counter=0; matched mask=0; ordered pointer=0. Table contents are NOT cleared.
//  - Reset asserted mid-RUN or after verdict returns to IDLE next edge; verdict is lost.
//  - States: IDLE -(start)-> RUN -(all matched)-> PASS; RUN -(mismatch)-> FAIL;
//    RUN -(cycle_cnt==TIMEOUT-1 with no verdict)-> TMO. PASS/FAIL/TMO held until reset.
//  - IDLE: exp_wr_en writes table[exp_idx]; exp_idx>=NUM_EXP is dropped. exp_wr_en outside
//    IDLE is ignored. mem_write ignored in IDLE. start and exp_wr_en same cycle: write then RUN.
//  - RUN, mem_write=1 sampled at posedge; store ignored if IGNORE_EN && data_addr_m==IGNORE_ADDR.
//    ORDERED=1: compare to table[ptr]; equal on addr and data -> ptr++, match_cnt++; else FAIL.
//    ORDERED=0: lowest-index unmatched entry with equal addr and data is marked matched,
//    match_cnt++; no such entry (incl. repeat of already-matched pair) -> FAIL.
//  - FAIL captures fail_addr/fail_data from the offending store, fail_code=1, in same edge.
//  - Verdict outputs are registered: visible the cycle after the deciding store/edge.
//  - Match of last entry -> PASS; a match and timeout in the same cycle resolves to PASS.
//  - cycle_cnt increments every RUN cycle, saturates; not reset by stores.
//  - Stores after a verdict are ignored; outputs unchanged.
// TESTING
//  1 ORDERED=1, table {(100,25)}; stores (96,7),(100,25) -> (96) skipped, pass=1 done=1, match_cnt=1
//  2 ORDERED=1, table {(100,25)}; store (104,25) -> fail=1, fail_code=1, fail_addr=104, fail_data=25
//  3 ORDERED=0, table {(0,1),(4,2),(8,3)}; stores (8,3),(0,1),(4,2) -> pass after third, cnt=3
//  4 ORDERED=0, table {(0,1),(4,2)}; stores (0,1),(0,1) -> fail on second, fail_code=1
//  5 TIMEOUT=16, no stores after start -> done=fail=1, fail_code=2 exactly 16 cycles after start
//  6 rst=0 mid-RUN after one match -> next edge IDLE, all outputs 0; restart with same table passes

Source files
------------

// File: rtl/store_checker.sv
// rtl/store_checker.sv - store stream checker against a preloaded expected-store table
// Drives sticky PASS/FAIL/TIMEOUT verdicts.

module store_checker #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_EXP     = 4,
    parameter logic [ADDR_W-1:0] IGNORE_ADDR = ADDR_W'(96),
    parameter bit                IGNORE_EN   = 1'b1,
    parameter bit                ORDERED     = 1'b1,
    parameter int                TIMEOUT     = 4096,
    localparam int               IDX_W       = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exp_wr_en,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              start,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_addr_m,
    input  logic [DATA_W-1:0] write_data_m,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [IDX_W:0]    match_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   LAST_IDX  = (IDX_W + 1)'(NUM_EXP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TMO
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]  tab_addr [NUM_EXP];
    logic [DATA_W-1:0]  tab_data [NUM_EXP];

    logic [CNT_W-1:0]   cycle_cnt, cycle_cnt_nxt;
    logic [NUM_EXP-1:0] matched, matched_nxt;
    logic [IDX_W:0]     match_cnt_nxt;
    logic [1:0]         fail_code_nxt;
    logic [ADDR_W-1:0]  fail_addr_nxt;
    logic [DATA_W-1:0]  fail_data_nxt;

    logic               idx_ok;
    logic               store_valid;
    logic               ord_hit;
    logic               found;
    logic [NUM_EXP-1:0] found_mask;
    logic               store_hit;
    logic [IDX_W-1:0]   ptr;

    // With a power-of-two table every encodable index is in range.
    generate
        if (NUM_EXP == (1 << IDX_W)) begin : g_idx_full
            assign idx_ok = 1'b1;
        end else begin : g_idx_part
            assign idx_ok = (exp_idx < IDX_W'(NUM_EXP));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst && state == S_IDLE && exp_wr_en && idx_ok) begin
            tab_addr[exp_idx] <= exp_addr;
            tab_data[exp_idx] <= exp_data;
        end
    end

    // In ordered mode the match count doubles as the table pointer.
    assign ptr         = match_cnt[IDX_W-1:0];
    assign store_valid = (state == S_RUN) && mem_write &&
                         !(IGNORE_EN && (data_addr_m == IGNORE_ADDR));
    assign ord_hit     = (tab_addr[ptr] == data_addr_m) && (tab_data[ptr] == write_data_m);

    always_comb begin
        found      = 1'b0;
        found_mask = '0;
        for (int i = 0; i < NUM_EXP; i++) begin
            if (!found && !matched[i] &&
                tab_addr[i] == data_addr_m && tab_data[i] == write_data_m) begin
                found         = 1'b1;
                found_mask[i] = 1'b1;
            end
        end
    end

    assign store_hit = ORDERED ? ord_hit : found;

    always_comb begin
        state_nxt     = state;
        cycle_cnt_nxt = cycle_cnt;
        matched_nxt   = matched;
        match_cnt_nxt = match_cnt;
        fail_code_nxt = fail_code;
        fail_addr_nxt = fail_addr;
        fail_data_nxt = fail_data;
        case (state)
            S_IDLE: begin
                cycle_cnt_nxt = '0;
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (cycle_cnt != '1) begin
                    cycle_cnt_nxt = cycle_cnt + CNT_W'(1);
                end
                if (store_valid) begin
                    if (store_hit) begin
                        match_cnt_nxt = match_cnt + (IDX_W + 1)'(1);
                        if (!ORDERED) begin
                            matched_nxt = matched | found_mask;
                        end
                        if (match_cnt == LAST_IDX) begin
                            state_nxt = S_PASS;
                        end
                    end else begin
                        state_nxt     = S_FAIL;
                        fail_code_nxt = 2'd1;
                        fail_addr_nxt = data_addr_m;
                        fail_data_nxt = write_data_m;
                    end
                end
                // A store verdict on the final cycle takes precedence over timeout.
                if (state_nxt == S_RUN && cycle_cnt == CNT_LAST) begin
                    state_nxt     = S_TMO;
                    fail_code_nxt = 2'd2;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cycle_cnt <= '0;
            matched   <= '0;
            match_cnt <= '0;
            fail_code <= 2'd0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            state     <= state_nxt;
            cycle_cnt <= cycle_cnt_nxt;
            matched   <= matched_nxt;
            match_cnt <= match_cnt_nxt;
            fail_code <= fail_code_nxt;
            fail_addr <= fail_addr_nxt;
            fail_data <= fail_data_nxt;
        end
    end

    assign done = (state == S_PASS) || (state == S_FAIL) || (state == S_TMO);
    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL) || (state == S_TMO);

endmodule

// File: tb/tb_store_checker.sv
// tb/tb_store_checker.sv - self-checking bench for store_checker
// Three differently configured instances share stimulus; each is checked against a model.

module tb_store_checker;

    localparam int P_NUM [3] = '{1, 3, 4};
    localparam int P_ORD [3] = '{1, 0, 1};
    localparam int P_TMO [3] = '{16, 64, 64};
    localparam int P_IGN [3] = '{1, 1, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  wr = '0;
    logic [1:0]  tb_idx = '0;
    logic [31:0] e_addr = '0, e_data = '0;
    logic        start = 1'b0, mw = 1'b0;
    logic [31:0] s_addr = '0, s_data = '0;

    logic [2:0]  o_done, o_pass, o_fail;
    logic [1:0]  o_code [3];
    logic [1:0]  o_mc0;
    logic [2:0]  o_mc1, o_mc2;
    logic [31:0] o_fa [3];
    logic [31:0] o_fd [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    store_checker #(.NUM_EXP(1), .ORDERED(1), .TIMEOUT(16), .IGNORE_EN(1)) u_a (
        .clk(clk), .rst(rst), .exp_wr_en(wr[0]), .exp_idx(tb_idx[0:0]),
        .exp_addr(e_addr), .exp_data(e_data), .start(start), .mem_write(mw),
        .data_addr_m(s_addr), .write_data_m(s_data),
        .done(o_done[0]), .pass(o_pass[0]), .fail(o_fail[0]), .fail_code(o_code[0]),
        .match_cnt(o_mc0), .fail_addr(o_fa[0]), .fail_data(o_fd[0]));

    store_checker #(.NUM_EXP(3), .ORDERED(0), .TIMEOUT(64), .IGNORE_EN(1)) u_b (
        .clk(clk), .rst(rst), .exp_wr_en(wr[1]), .exp_idx(tb_idx),
        .exp_addr(e_addr), .exp_data(e_data), .start(start), .mem_write(mw),
        .data_addr_m(s_addr), .write_data_m(s_data),
        .done(o_done[1]), .pass(o_pass[1]), .fail(o_fail[1]), .fail_code(o_code[1]),
        .match_cnt(o_mc1), .fail_addr(o_fa[1]), .fail_data(o_fd[1]));

    store_checker #(.NUM_EXP(4), .ORDERED(1), .TIMEOUT(64), .IGNORE_EN(0)) u_c (
        .clk(clk), .rst(rst), .exp_wr_en(wr[2]), .exp_idx(tb_idx),
        .exp_addr(e_addr), .exp_data(e_data), .start(start), .mem_write(mw),
        .data_addr_m(s_addr), .write_data_m(s_data),
        .done(o_done[2]), .pass(o_pass[2]), .fail(o_fail[2]), .fail_code(o_code[2]),
        .match_cnt(o_mc2), .fail_addr(o_fa[2]), .fail_data(o_fd[2]));

    // Reference model: 0 idle, 1 running, 2 passed, 3 mismatch, 4 timed out.
    int          m_st [3];
    logic [31:0] m_ta [3][4];
    logic [31:0] m_td [3][4];
    bit          m_used [3][4];
    int          m_mc [3];
    int          m_el [3];
    logic [31:0] m_fa [3];
    logic [31:0] m_fd [3];

    function automatic logic [71:0] mk(bit dn, bit ps, bit fl, int code, int mc,
                                       logic [31:0] fa, logic [31:0] fd);
        return {dn, ps, fl, 2'(code), 3'(mc), fa, fd};
    endfunction

    function automatic logic [71:0] exp_vec(int k);
        int code;
        code = (m_st[k] == 3) ? 1 : ((m_st[k] == 4) ? 2 : 0);
        return mk(m_st[k] >= 2, m_st[k] == 2, m_st[k] >= 3, code, m_mc[k], m_fa[k], m_fd[k]);
    endfunction

    function automatic logic [71:0] act_vec(int k);
        logic [2:0] mc;
        mc = (k == 0) ? {1'b0, o_mc0} : ((k == 1) ? o_mc1 : o_mc2);
        return {o_done[k], o_pass[k], o_fail[k], o_code[k], mc, o_fa[k], o_fd[k]};
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                m_st[k] = 0; m_mc[k] = 0; m_el[k] = 0; m_fa[k] = '0; m_fd[k] = '0;
                for (int j = 0; j < 4; j++) m_used[k][j] = 1'b0;
            end else if (m_st[k] == 0) begin
                int idx;
                idx = (k == 0) ? int'(tb_idx[0]) : int'(tb_idx);
                if (wr[k] && idx < P_NUM[k]) begin
                    m_ta[k][idx] = e_addr;
                    m_td[k][idx] = e_data;
                end
                if (start) m_st[k] = 1;
            end else if (m_st[k] == 1) begin
                m_el[k]++;
                if (mw && !(P_IGN[k] != 0 && s_addr == 32'd96)) begin
                    int hit;
                    hit = -1;
                    if (P_ORD[k] != 0) begin
                        if (m_ta[k][m_mc[k]] == s_addr && m_td[k][m_mc[k]] == s_data) hit = m_mc[k];
                    end else begin
                        for (int j = 0; j < P_NUM[k]; j++)
                            if (hit < 0 && !m_used[k][j] && m_ta[k][j] == s_addr && m_td[k][j] == s_data)
                                hit = j;
                    end
                    if (hit >= 0) begin
                        m_used[k][hit] = 1'b1;
                        m_mc[k]++;
                        if (m_mc[k] == P_NUM[k]) m_st[k] = 2;
                    end else begin
                        m_st[k] = 3; m_fa[k] = s_addr; m_fd[k] = s_data;
                    end
                end
                if (m_st[k] == 1 && m_el[k] >= P_TMO[k]) m_st[k] = 4;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (act_vec(k) !== exp_vec(k)) begin
                fails++;
                $display("FAIL model_inst%0d t=%0t: got %h want %h", k, $time, act_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic check_one(input int k, input logic [71:0] want, input int tag);
        tests++;
        if (act_vec(k) !== want) begin
            fails++;
            $display("FAIL directed%0d inst%0d: got %h want %h", tag, k, act_vec(k), want);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit m,
                        input logic [31:0] a, input logic [31:0] d);
        rst = r; start = s; mw = m; s_addr = a; s_data = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        wr = '0;
    endtask

    task automatic load(input int k, input int idx, input logic [31:0] a, input logic [31:0] d);
        wr = '0; wr[k] = 1'b1; tb_idx = 2'(idx); e_addr = a; e_data = d;
        step(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    typedef struct {
        int          inst;
        bit          rst_n;
        bit          st;
        bit          mw;
        logic [31:0] a;
        logic [31:0] d;
        logic [71:0] want;
    } vec_t;

    function automatic vec_t v(int inst, bit r, bit s, bit m, logic [31:0] a, logic [31:0] d,
                               logic [71:0] want);
        vec_t x;
        x.inst = inst; x.rst_n = r; x.st = s; x.mw = m; x.a = a; x.d = d; x.want = want;
        return x;
    endfunction

    vec_t vecs [$];

    initial begin
        logic [71:0] z;
        logic [31:0] pool [5];
        z = mk(0, 0, 0, 0, 0, 0, 0);
        pool = '{32'd0, 32'd4, 32'd8, 32'd96, 32'd100};

        // spec scenarios 1, 2, 3, 4, 6 as one-cycle records
        vecs.push_back(v(0, 0, 0, 0, 0, 0, z));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, z));
        vecs.push_back(v(0, 1, 0, 1, 96, 7, z));
        vecs.push_back(v(0, 1, 0, 1, 100, 25, mk(1, 1, 0, 0, 1, 0, 0)));
        vecs.push_back(v(0, 1, 0, 1, 100, 26, mk(1, 1, 0, 0, 1, 0, 0)));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, z));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, z));
        vecs.push_back(v(0, 1, 0, 1, 104, 25, mk(1, 0, 1, 1, 0, 104, 25)));
        vecs.push_back(v(0, 1, 0, 1, 100, 25, mk(1, 0, 1, 1, 0, 104, 25)));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, z));
        vecs.push_back(v(1, 1, 1, 0, 0, 0, z));
        vecs.push_back(v(1, 1, 0, 1, 8, 3, mk(0, 0, 0, 0, 1, 0, 0)));
        vecs.push_back(v(1, 1, 0, 1, 0, 1, mk(0, 0, 0, 0, 2, 0, 0)));
        vecs.push_back(v(1, 1, 0, 1, 4, 2, mk(1, 1, 0, 0, 3, 0, 0)));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, z));
        vecs.push_back(v(1, 1, 1, 0, 0, 0, z));
        vecs.push_back(v(1, 1, 0, 1, 0, 1, mk(0, 0, 0, 0, 1, 0, 0)));
        vecs.push_back(v(1, 1, 0, 1, 0, 1, mk(1, 0, 1, 1, 1, 0, 1)));
        vecs.push_back(v(2, 0, 0, 0, 0, 0, z));
        vecs.push_back(v(2, 1, 1, 0, 0, 0, z));
        vecs.push_back(v(2, 1, 0, 1, 10, 11, mk(0, 0, 0, 0, 1, 0, 0)));
        vecs.push_back(v(2, 0, 0, 0, 0, 0, z));
        vecs.push_back(v(2, 1, 1, 0, 0, 0, z));
        vecs.push_back(v(2, 1, 0, 1, 10, 11, mk(0, 0, 0, 0, 1, 0, 0)));
        vecs.push_back(v(2, 1, 0, 1, 96, 12, mk(0, 0, 0, 0, 2, 0, 0)));
        vecs.push_back(v(2, 1, 0, 1, 20, 13, mk(0, 0, 0, 0, 3, 0, 0)));
        vecs.push_back(v(2, 1, 0, 1, 30, 14, mk(1, 1, 0, 0, 4, 0, 0)));

        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);

        load(0, 0, 100, 25);
        load(0, 1, 55, 55);
        load(1, 0, 0, 1);
        load(1, 1, 4, 2);
        load(1, 2, 8, 3);
        load(1, 3, 77, 77);
        load(2, 0, 10, 11);
        load(2, 1, 96, 12);
        load(2, 2, 20, 13);
        load(2, 3, 30, 14);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].st, vecs[i].mw, vecs[i].a, vecs[i].d);
            check_one(vecs[i].inst, vecs[i].want, i);
        end

        // timeout exactly TIMEOUT cycles after the start edge
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        for (int c = 1; c <= 16; c++) begin
            step(1'b1, 1'b0, 1'b0, '0, '0);
            check_one(0, (c == 16) ? mk(1, 0, 1, 2, 0, 0, 0) : z, 100 + c);
        end

        // final match landing on the timeout edge resolves to pass
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        for (int c = 1; c <= 15; c++) step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b1, 100, 25);
        check_one(0, mk(1, 1, 0, 0, 1, 0, 0), 200);

        for (int ep = 0; ep < 40; ep++) begin
            step(1'b0, 1'b0, 1'b0, '0, '0);
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(0, 1) == 1)
                    load($urandom_range(0, 2), $urandom_range(0, 3),
                         pool[$urandom_range(0, 4)], 32'($urandom_range(0, 3)));
            end
            step(1'b1, 1'b1, 1'b0, '0, '0);
            for (int c = 0; c < 30; c++) begin
                int k, j;
                logic [31:0] a, d;
                bit r, s, m;
                r = ($urandom_range(0, 39) != 0);
                s = ($urandom_range(0, 9) == 0);
                m = ($urandom_range(0, 9) < 6);
                wr = 3'($urandom_range(0, 7)) & {3{$urandom_range(0, 3) == 0}};
                tb_idx = 2'($urandom_range(0, 3));
                e_addr = pool[$urandom_range(0, 4)];
                e_data = 32'($urandom_range(0, 3));
                k = $urandom_range(0, 2);
                if ($urandom_range(0, 9) < 7) begin
                    j = (P_ORD[k] != 0) ? (m_mc[k] % P_NUM[k]) : $urandom_range(0, P_NUM[k] - 1);
                    a = m_ta[k][j];
                    d = m_td[k][j];
                end else begin
                    a = pool[$urandom_range(0, 4)];
                    d = 32'($urandom_range(0, 3));
                end
                step(r, s, m, a, d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
